// File: rtl/byte_packer_wr.sv
// rtl/byte_packer_wr.sv - packs a byte stream into FIFO words on clk_a
// Little-endian lane fill, s_last closes a short word with PAD_BYTE lanes.
module byte_packer_wr #(
  parameter int         FIFO_WIDTH = 16,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic                  clk_a,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [FIFO_WIDTH-1:0] din_a,
  output logic                  wen_a,
  input  logic                  full,
  output logic [15:0]           words_written,
  output logic                  busy
);

  localparam int BPW = FIFO_WIDTH / 8;
  localparam int IW  = $clog2(BPW);
  typedef logic [IW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(BPW - 1);

  logic [FIFO_WIDTH-1:0] acc_q, acc_d;
  logic [FIFO_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_valid_q, hold_valid_d;
  idx_t                  idx_q, idx_d;
  logic [15:0]           words_q, words_d;

  logic                  accept;
  logic                  closing;
  logic [FIFO_WIDTH-1:0] word;

  assign s_ready       = !(hold_valid_q && full);
  // The FIFO is reset alongside us, so a pending word must not be pushed during rst.
  assign wen_a         = hold_valid_q && !full && !rst;
  assign din_a         = hold_q;
  assign words_written = words_q;
  assign busy          = hold_valid_q || (idx_q != '0);

  assign accept  = s_valid && s_ready;
  assign closing = accept && ((idx_q == LAST_IDX) || s_last);

  always_comb begin
    word = '0;
    for (int k = 0; k < BPW; k++) begin
      if (k < int'(idx_q))
        word[8*k +: 8] = acc_q[8*k +: 8];
      else if (k == int'(idx_q))
        word[8*k +: 8] = s_data;
      else
        word[8*k +: 8] = PAD_BYTE;
    end
  end

  always_comb begin
    acc_d        = acc_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    idx_d        = idx_q;
    words_d      = words_q;

    if (wen_a) begin
      hold_valid_d = 1'b0;
      words_d      = words_q + 16'd1;
    end

    // A close in the same cycle as a drain simply reloads the holding register.
    if (closing) begin
      hold_d       = word;
      hold_valid_d = 1'b1;
      idx_d        = '0;
      acc_d        = {BPW{PAD_BYTE}};
    end else if (accept) begin
      for (int k = 0; k < BPW; k++) begin
        if (k == int'(idx_q))
          acc_d[8*k +: 8] = s_data;
      end
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_a) begin
    if (rst) begin
      acc_q        <= {BPW{PAD_BYTE}};
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      idx_q        <= '0;
      words_q      <= '0;
    end else begin
      acc_q        <= acc_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      idx_q        <= idx_d;
      words_q      <= words_d;
    end
  end

endmodule

// File: tb/tb_byte_packer_wr.sv
// tb/tb_byte_packer_wr.sv - self-checking bench for byte_packer_wr
// Table vectors, hand sequences and a queue-based reference model.
module tb_byte_packer_wr;

  localparam int W   = 16;
  localparam int BPW = W / 8;
  localparam logic [7:0] PAD = 8'hFF;

  logic          clk_a = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          full = 1'b0;
  logic          s_ready;
  logic [W-1:0]  din_a;
  logic          wen_a;
  logic [15:0]   words_written;
  logic          busy;

  byte_packer_wr #(.FIFO_WIDTH(W), .PAD_BYTE(PAD)) dut (
    .clk_a(clk_a), .rst(rst), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .din_a(din_a), .wen_a(wen_a),
    .full(full), .words_written(words_written), .busy(busy)
  );

  always #5 clk_a = ~clk_a;

  int total = 0;
  int bad = 0;

  // Reference model: bytes of the open word, held word, write count.
  logic [7:0]   cur[$];
  logic [W-1:0] m_hold = '0;
  logic         m_hv = 1'b0;
  logic [15:0]  m_ww = '0;
  logic [W-1:0] wr_log[$];

  typedef struct {
    logic [7:0]  d;
    logic        v, l, f;
    logic        e_ready, e_wen;
    logic [15:0] e_din;
    logic        e_busy;
    logic [15:0] e_ww;
  } vec_t;
  vec_t vec[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack_cur();
    logic [W-1:0] w;
    w = {BPW{PAD}};
    for (int k = 0; k < cur.size(); k++) w[8*k +: 8] = cur[k];
    return w;
  endfunction

  task automatic model_update(input logic [7:0] d, input logic v, input logic l,
                              input logic f, input logic r);
    logic rdy;
    if (r) begin
      cur.delete();
      m_hold = '0;
      m_hv   = 1'b0;
      m_ww   = '0;
    end else begin
      rdy = !(m_hv && f);
      if (m_hv && !f) begin
        m_hv = 1'b0;
        m_ww = m_ww + 16'd1;
      end
      if (v && rdy) begin
        cur.push_back(d);
        if (cur.size() == BPW || l) begin
          m_hold = pack_cur();
          m_hv   = 1'b1;
          cur.delete();
        end
      end
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic l,
                       input logic f, input logic r);
    @(negedge clk_a);
    s_data = d; s_valid = v; s_last = l; full = f; rst = r;
    #1;
    if (wen_a) wr_log.push_back(din_a);
  endtask

  task automatic tick();
    @(posedge clk_a);
    model_update(s_data, s_valid, s_last, full, rst);
  endtask

  task automatic check_model();
    chk("ready", s_ready, !(m_hv && full));
    chk("wen", wen_a, m_hv && !full && !rst);
    chk("din", din_a, m_hold);
    chk("busy", busy, m_hv || (cur.size() != 0));
    chk("words_written", words_written, m_ww);
  endtask

  task automatic step(input logic [7:0] d, input logic v, input logic l,
                      input logic f, input logic r);
    drive(d, v, l, f, r);
    check_model();
    tick();
  endtask

  int wr0;
  logic ready_dropped;

  initial begin
    vec[0]  = '{8'h11, 1, 0, 0, 1, 0, 16'h0000, 0, 16'd0};
    vec[1]  = '{8'h22, 1, 0, 0, 1, 0, 16'h0000, 1, 16'd0};
    vec[2]  = '{8'h33, 1, 0, 0, 1, 1, 16'h2211, 1, 16'd0};
    vec[3]  = '{8'h44, 1, 1, 0, 1, 0, 16'h2211, 1, 16'd1};
    vec[4]  = '{8'h00, 0, 0, 0, 1, 1, 16'h4433, 1, 16'd1};
    vec[5]  = '{8'h00, 0, 0, 0, 1, 0, 16'h4433, 0, 16'd2};
    vec[6]  = '{8'hAA, 1, 1, 0, 1, 0, 16'h4433, 0, 16'd2};
    vec[7]  = '{8'h00, 0, 0, 0, 1, 1, 16'hFFAA, 1, 16'd2};
    vec[8]  = '{8'h00, 0, 0, 0, 1, 0, 16'hFFAA, 0, 16'd3};
    vec[9]  = '{8'h01, 1, 0, 0, 1, 0, 16'hFFAA, 0, 16'd3};
    vec[10] = '{8'h02, 1, 0, 0, 1, 0, 16'hFFAA, 1, 16'd3};
    for (int i = 11; i < 16; i++)
      vec[i] = '{8'h03, 1, 0, 1, 0, 0, 16'h0201, 1, 16'd3};
    vec[16] = '{8'h03, 1, 0, 0, 1, 1, 16'h0201, 1, 16'd3};
    vec[17] = '{8'h04, 1, 1, 0, 1, 0, 16'h0201, 1, 16'd4};
    vec[18] = '{8'h00, 0, 0, 0, 1, 1, 16'h0403, 1, 16'd4};
    vec[19] = '{8'h00, 0, 0, 0, 1, 0, 16'h0403, 0, 16'd5};

    // Reset state
    drive(8'h00, 0, 0, 0, 1);
    tick();
    drive(8'h00, 0, 0, 0, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_wen", wen_a, 0);
    chk("rst_din", din_a, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ww", words_written, 0);
    tick();

    // Table: basic packing, padded frame, full stall
    wr_log.delete();
    for (int i = 0; i < 20; i++) begin
      drive(vec[i].d, vec[i].v, vec[i].l, vec[i].f, 0);
      chk($sformatf("vec%0d_ready", i), s_ready, vec[i].e_ready);
      chk($sformatf("vec%0d_wen", i), wen_a, vec[i].e_wen);
      chk($sformatf("vec%0d_din", i), din_a, vec[i].e_din);
      chk($sformatf("vec%0d_busy", i), busy, vec[i].e_busy);
      chk($sformatf("vec%0d_ww", i), words_written, vec[i].e_ww);
      tick();
    end
    chk("tab_nwr", wr_log.size(), 5);
    if (wr_log.size() == 5) begin
      chk("tab_wr0", wr_log[0], 16'h2211);
      chk("tab_wr1", wr_log[1], 16'h4433);
      chk("tab_wr2", wr_log[2], 16'hFFAA);
      chk("tab_wr3", wr_log[3], 16'h0201);
      chk("tab_wr4", wr_log[4], 16'h0403);
    end

    // Continuous 200-byte stream
    step(8'h00, 0, 0, 0, 1);
    wr_log.delete();
    ready_dropped = 1'b0;
    for (int i = 0; i < 200; i++) begin
      drive(8'(i), 1, 0, 0, 0);
      if (!s_ready) ready_dropped = 1'b1;
      check_model();
      tick();
    end
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    chk("stream_ready_drop", ready_dropped, 0);
    chk("stream_nwr", wr_log.size(), 100);
    chk("stream_ww", words_written, 100);
    for (int j = 0; j < wr_log.size() && j < 100; j++)
      chk($sformatf("stream_word%0d", j), wr_log[j], {8'(2*j+1), 8'(2*j)});

    // Reset discards held and partial words
    step(8'hA0, 1, 0, 0, 1);
    step(8'hA0, 1, 0, 0, 0);
    step(8'hA1, 1, 0, 0, 0);
    wr_log.delete();
    step(8'h00, 0, 0, 0, 1);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'hA2, 1, 0, 0, 0);
    step(8'h00, 0, 0, 0, 1);
    chk("rstdisc_nwr", wr_log.size(), 0);
    step(8'h01, 1, 0, 0, 0);
    step(8'h02, 1, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    chk("rstdisc_nwr2", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("rstdisc_word", wr_log[0], 16'h0201);
    chk("rstdisc_ww", words_written, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++)
      step(8'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    step(8'h00, 0, 0, 0, 0);
    step(8'h00, 0, 0, 0, 0);

    // Counter wrap: 65536 single-byte frames
    step(8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 65536; i++) step(8'(i), 1, 1, 0, 0);
    step(8'h00, 0, 0, 0, 0);
    drive(8'h00, 0, 0, 0, 0);
    chk("wrap_zero", words_written, 0);
    chk("wrap_idle", busy, 0);
    tick();
    step(8'h5A, 1, 1, 0, 0);
    drive(8'h00, 0, 0, 0, 0);
    chk("wrap_din", din_a, 16'hFF5A);
    chk("wrap_wen", wen_a, 1);
    tick();
    drive(8'h00, 0, 0, 0, 0);
    chk("wrap_one", words_written, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_packer_wr.md
# byte_packer_wr

Write-side front end for the dual-clock FIFO: accepts a byte stream on clk_a through a valid/ready handshake and packs consecutive bytes into FIFO_WIDTH-bit words. Completed words are presented on the FIFO write port (din_a/wen_a), and the block stalls on the FIFO full flag. Frames ending mid-word are padded so that no byte is ever stranded in the packer.

## Interface
- FIFO_WIDTH, 16, FIFO word width; must be a multiple of 8, minimum 16.
- PAD_BYTE, 8'h00, fill value for unused byte lanes of a word closed by s_last.
- BPW (localparam), FIFO_WIDTH/8, bytes per word; byte index counter is $clog2(BPW) bits.

Ports:
- clk_a  input  1  write-domain clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset; shared with the FIFO.
- s_data  input  8  incoming byte.
- s_valid  input  1  s_data valid.
- s_last  input  1  qualifies the final byte of a frame; sampled only on acceptance.
- s_ready  output  1  packer can accept a byte this cycle.
- din_a  output  FIFO_WIDTH  word to FIFO; holding-register contents.
- wen_a  output  1  FIFO write enable.
- full  input  1  FIFO full flag.
- words_written  output  16  count of words transferred to FIFO; wraps at 2^16.
- busy  output  1  accumulator or holding register non-empty.

## Operation
- Byte accepted on an edge where s_valid && s_ready.
- Packing is little-endian: the first byte of a word goes to din_a[7:0], byte k to [8k+7:8k].
- Accumulator plus byte index idx (0..BPW-1). An accepted byte is written to lane idx.
- A word closes when the accepted byte has idx == BPW-1, or s_last=1 is accepted.
- On close: lanes above idx are filled with PAD_BYTE, the word is moved to the holding register, hold_valid is set, idx returns to 0, and the accumulator is cleared to PAD_BYTE in all lanes.
- A non-closing accept does idx <= idx+1.
- wen_a = hold_valid && !full, combinational. A transfer occurs on each edge where wen_a=1; it clears hold_valid and increments words_written.
- s_ready = !(hold_valid && full).
- Close and drain in the same cycle: the holding register is reloaded with the new word and hold_valid stays 1.
- s_last on a byte with idx == BPW-1: a normal full word, no padding.
- s_last alone never creates an empty word; there is no flush without a byte.
- busy = hold_valid || (idx != 0).
- States, implicit in (idx, hold_valid):
  - IDLE (0,0)
  - FILL (idx>0, 0)
  - HOLD (any, 1); stays in HOLD while full=1.
  - HOLD -> IDLE/FILL when a transfer occurs with no simultaneous close.

## Timing
- Reset values: s_ready=1, wen_a=0, din_a=0, words_written=0, busy=0, idx=0.
- Reset mid-operation discards the partial word and the held word. Nothing is written during or after the rst cycle until new bytes arrive.
- Latency: a word closed at edge N gives wen_a=1 during cycle N+1 if full=0, and the FIFO captures it at edge N+1.
- Sustained throughput is one byte per cycle: with full=0, s_ready stays 1 continuously and wen_a pulses once every BPW accepted bytes.
- full rising while hold_valid=1:
  - wen_a drops in the same cycle and s_ready drops.
  - din_a is held stable until the transfer.
- full falling: wen_a=1 and s_ready=1 in the same cycle.
- din_a changes only on a close edge and is otherwise stable.
- s_data is ignored when s_ready=0; upstream must hold the byte.

## Test plan
- Reset, then bytes 11,22,33,44 with full=0 and s_last on 44 -> two writes, din_a=16'h2211 then 16'h4433. Each wen_a is one cycle, one edge after the closing byte. words_written=2.
- Frame 0xAA with s_last=1, PAD_BYTE=8'hFF -> one write din_a=16'hFFAA. busy returns to 0 after the transfer.
- full=1 held for 5 cycles after a word closes -> wen_a=0 and s_ready=0 throughout, din_a stable. The single write occurs on the first edge after full drops; no byte is lost or duplicated.
- Continuous 200-byte stream with full=0 -> s_ready never drops. Exactly 100 writes in ascending byte order; words_written=100.
- rst asserted after 1 byte of a word with a held word pending -> no write occurs. The next 2 bytes (0x01,0x02) produce din_a=16'h0201 and words_written=1.
- Pre-load words_written by sending 65536 words -> counter wraps to 0. The next write shows 1.
